// File: rtl/spi_parity_word_fsm_pkg.sv
// Package form of the shared SPI parity definitions, plus the saturating counter helper.
`include "spi_parity_defs.vh"

package spi_parity_word_fsm_pkg;

  localparam logic [1:0] ST_IDLE = `SPI_ST_IDLE;
  localparam logic [1:0] ST_DATA = `SPI_ST_DATA;
  localparam logic [1:0] ST_PAR  = `SPI_ST_PAR;

  localparam logic [7:0] ERR_CNT_MAX = `SPI_ERR_CNT_MAX;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_parity_acc.sv
// Word accumulator: MSB-first shift register, running parity and received-bit count.
module spi_parity_acc #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 1,
  parameter int CNT_W      = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift,
  input  logic              bit_in,
  output logic [DATA_W-1:0] word,
  output logic              parity,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam logic PAR_INIT = (ODD_PARITY != 0);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      parity_d  = PAR_INIT;
      bit_cnt_d = '0;
    end else if (shift) begin
      shift_d   = {shift_q[DATA_W-2:0], bit_in};
      parity_d  = parity_q ^ bit_in;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      parity_q  <= PAR_INIT;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign word    = shift_q;
  assign parity  = parity_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/spi_parity_defs.vh
// Shared state encodings and error-counter ceiling for the SPI parity word receiver.
`ifndef SPI_PARITY_DEFS_VH
`define SPI_PARITY_DEFS_VH
`define SPI_ST_IDLE     2'd0
`define SPI_ST_DATA     2'd1
`define SPI_ST_PAR      2'd2
`define SPI_ERR_CNT_MAX 8'hFF
`endif

// File: rtl/spi_parity_word_fsm.sv
// SPI parity word receiver: frame FSM, output pulses and parity error counter.
// Define SPI_PARITY_ERR_CNT_EN to build the saturating err_count; otherwise it reads 8'h00.
module spi_parity_word_fsm
  import spi_parity_word_fsm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sample,
  input  logic              in,
  output logic              parity_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              word_valid,
  output logic              parity_err,
  output logic              abort,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              word_valid_q, word_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;

  logic              acc_clr, acc_shift;
  logic [DATA_W-1:0] acc_word;
  logic              acc_parity;
  logic [CNT_W-1:0]  acc_cnt;

  spi_parity_acc #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD_PARITY),
    .CNT_W      (CNT_W)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr     (acc_clr),
    .shift   (acc_shift),
    .bit_in  (in),
    .word    (acc_word),
    .parity  (acc_parity),
    .bit_cnt (acc_cnt)
  );

  always_comb begin
    state_d      = state_q;
    data_out_d   = data_out_q;
    word_valid_d = 1'b0;
    parity_err_d = 1'b0;
    abort_d      = 1'b0;
    acc_clr      = 1'b0;
    acc_shift    = 1'b0;
    if (cs) begin
      // Deselect drops any partial frame; only a frame with bits already taken is an abort.
      state_d = ST_IDLE;
      acc_clr = 1'b1;
      abort_d = (acc_cnt != '0) || (state_q == ST_PAR);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_DATA;
          acc_shift = sample;
        end
        ST_DATA: begin
          if (sample) begin
            acc_shift = 1'b1;
            if (acc_cnt == CNT_W'(DATA_W - 1)) state_d = ST_PAR;
          end
        end
        ST_PAR: begin
          if (sample) begin
            data_out_d   = acc_word;
            word_valid_d = 1'b1;
            parity_err_d = (in != acc_parity);
            acc_clr      = 1'b1;
            state_d      = ST_DATA;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      data_out_q   <= '0;
      word_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      word_valid_q <= word_valid_d;
      parity_err_q <= parity_err_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
    end
  end

`ifdef SPI_PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (parity_err_d) err_cnt_d = sat_inc8(err_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= 8'h00;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

  assign parity_bit = acc_parity;
  assign data_out   = data_out_q;
  assign word_valid = word_valid_q;
  assign parity_err = parity_err_q;
  assign abort      = abort_q;
  assign busy       = busy_q;

endmodule
